// File: rtl/wrr_pop_controller_if.sv
// Queue-side and output-FIFO-side signals of the WRR pop controller.
// The master end is the controller; the slave end is the FIFO fabric.
interface wrr_pop_controller_if #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8
);
    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in;
    logic                                out_almost_full;
    logic [QUEUE_QUANTITY-1:0]           pop;
    logic [DATA_BITS-1:0]                data_out;
    logic                                push;

    modport master (
        input  buf_empty,
        input  data_in,
        input  out_almost_full,
        output pop,
        output data_out,
        output push
    );

    modport slave (
        output buf_empty,
        output data_in,
        output out_almost_full,
        input  pop,
        input  data_out,
        input  push
    );
endinterface

// File: rtl/wrr_pop_controller.sv
// Weighted round-robin dequeue controller: walks a (queue, weight) table
// and forwards up to weight words per visit into the output FIFO.
module wrr_pop_controller #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int TABLE_SIZE     = 8,
    parameter int MAX_WEIGHT     = 64,
    localparam int QW = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1,
    localparam int SW = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1,
    localparam int WW = (MAX_WEIGHT > 1) ? $clog2(MAX_WEIGHT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic [TABLE_SIZE*WW-1:0] pesos,
    input  logic [TABLE_SIZE*QW-1:0] selecciones,
    output logic [SW-1:0]            slot,
    output logic [1:0]               state,
    wrr_pop_controller_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [QW-1:0]        q_q, q_d;
    logic [WW-1:0]        credit_q, credit_d;
    logic                 push_q, push_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    logic [QW-1:0]        cfg_q;
    logic [WW-1:0]        cfg_w;
    logic                 q_empty;
    logic                 pop_en;

    assign cfg_q = selecciones[int'(slot_q)*QW +: QW];
    assign cfg_w = pesos[int'(slot_q)*WW +: WW];

    // Out-of-range queue indices behave as permanently empty queues.
    always_comb begin
        q_empty = 1'b1;
        if (int'(q_q) < QUEUE_QUANTITY) q_empty = bus.buf_empty[q_q];
    end

    assign pop_en = !rst && enb && (state_q == SERVE)
                    && !bus.out_almost_full && !q_empty;

    assign bus.pop      = pop_en ? (QUEUE_QUANTITY'(1) << q_q) : '0;
    assign bus.push     = push_q;
    assign bus.data_out = data_q;
    assign slot         = slot_q;
    assign state        = state_q;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        q_d      = q_q;
        credit_d = credit_q;
        push_d   = pop_en;
        data_d   = data_q;
        if (pop_en) data_d = bus.data_in[int'(q_q)*DATA_BITS +: DATA_BITS];
        if (enb) begin
            case (state_q)
                IDLE: state_d = LOAD;
                LOAD: begin
                    q_d      = cfg_q;
                    credit_d = cfg_w;
                    if (cfg_w == '0) slot_d = slot_q + 1'b1;
                    else             state_d = SERVE;
                end
                SERVE: begin
                    // Empty queue forfeits the rest of its credit.
                    if (q_empty) begin
                        slot_d  = slot_q + 1'b1;
                        state_d = LOAD;
                    end else if (!bus.out_almost_full) begin
                        if (credit_q == WW'(1)) begin
                            slot_d  = slot_q + 1'b1;
                            state_d = LOAD;
                        end else begin
                            credit_d = credit_q - 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            q_q      <= '0;
            credit_q <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            q_q      <= q_d;
            credit_q <= credit_d;
            push_q   <= push_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_wrr_pop_controller.sv
// Directed bench for wrr_pop_controller with a small FIFO-content model
// feeding the queue heads and a log of every pushed word.
module tb_wrr_pop_controller;

    logic        clk;
    logic        rst;
    logic        enb;
    logic [47:0] pesos;
    logic [15:0] selecciones;
    logic [2:0]  slot;
    logic [1:0]  state;

    wrr_pop_controller_if #(.QUEUE_QUANTITY(4), .DATA_BITS(8)) bus ();

    wrr_pop_controller dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .pesos       (pesos),
        .selecciones (selecciones),
        .slot        (slot),
        .state       (state),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int         cnt [4];
    logic [5:0] seq [4];
    int         n;
    logic [7:0] pw [$];
    int         pt [$];
    logic [1:0] st [200];
    logic [2:0] sl [200];
    logic [5:0] cr [200];
    logic [3:0] pp [200];
    logic [3:0] pop_or;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_q();
        for (int k = 0; k < 4; k++) begin
            bus.buf_empty[k]      = (cnt[k] == 0);
            bus.data_in[k*8 +: 8] = 8'(k * 64) + {2'b00, seq[k]};
        end
    endtask

    task automatic tick();
        logic [3:0] p;
        #1;
        p = bus.pop;
        @(posedge clk);
        #1;
        n++;
        for (int k = 0; k < 4; k++)
            if (p[k] && cnt[k] > 0) begin
                cnt[k]--;
                seq[k]++;
            end
        drive_q();
        if (bus.push) begin
            pw.push_back(bus.data_out);
            pt.push_back(n);
        end
        pop_or |= p;
        st[n] = state;
        sl[n] = slot;
        cr[n] = dut.credit_q;
        pp[n] = p;
    endtask

    task automatic set_slot(input int i, input int q, input int w);
        selecciones[i*2 +: 2] = 2'(q);
        pesos[i*6 +: 6]       = 6'(w);
    endtask

    task automatic fill(input int c0, input int c1, input int c2, input int c3);
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
        for (int k = 0; k < 4; k++) seq[k] = '0;
        drive_q();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enb = 1'b0;
        bus.out_almost_full = 1'b0;
        tick();
        tick();
        n = 0;
        pw.delete();
        pt.delete();
        pop_or = '0;
    endtask

    int q0c;
    int last0;

    initial begin
        pesos       = '0;
        selecciones = '0;
        fill(0, 0, 0, 0);
        n = 0;
        pop_or = '0;
        do_reset();

        // reset state
        chk("rst_state", 32'(state), 0);
        chk("rst_slot", 32'(slot), 0);
        chk("rst_push", 32'(bus.push), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_credit", 32'(dut.credit_q), 0);
        chk("rst_q", 32'(dut.q_q), 0);
        enb = 1'b1;
        #1;
        chk("rst_pop", 32'(bus.pop), 0);

        // basic WRR
        for (int i = 0; i < 8; i++) set_slot(i, i % 4, (i < 4) ? 2 : 0);
        fill(4, 4, 4, 4);
        rst = 1'b0;
        enb = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        begin
            logic [7:0] ew [16];
            int         et [16];
            ew = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h80, 8'h81, 8'hC0, 8'hC1,
                   8'h02, 8'h03, 8'h42, 8'h43, 8'h82, 8'h83, 8'hC2, 8'hC3};
            et = '{3, 4, 6, 7, 9, 10, 12, 13, 19, 20, 22, 23, 25, 26, 28, 29};
            chk("wrr_count", 32'(pw.size()), 16);
            for (int i = 0; i < 16 && i < pw.size(); i++) begin
                chk($sformatf("wrr_word%0d", i), 32'(pw[i]), 32'(ew[i]));
                chk($sformatf("wrr_tick%0d", i), 32'(pt[i]), 32'(et[i]));
            end
        end
        chk("wrr_load_s4", {st[13], 1'b0, sl[13]}, {2'd1, 4'd4});
        chk("wrr_load_s7", {st[16], 1'b0, sl[16]}, {2'd1, 4'd7});

        // empty skip
        do_reset();
        fill(4, 0, 4, 4);
        rst = 1'b0;
        enb = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        begin
            logic [7:0] ew [6];
            int         et [6];
            ew = '{8'h00, 8'h01, 8'h80, 8'h81, 8'hC0, 8'hC1};
            et = '{3, 4, 8, 9, 11, 12};
            chk("skip_count", 32'(pw.size()), 6);
            for (int i = 0; i < 6 && i < pw.size(); i++) begin
                chk($sformatf("skip_word%0d", i), 32'(pw[i]), 32'(ew[i]));
                chk($sformatf("skip_tick%0d", i), 32'(pt[i]), 32'(et[i]));
            end
        end
        chk("skip_nopop_q1", 32'(pop_or[1]), 0);
        chk("skip_load_s1", {st[4], 1'b0, sl[4]}, {2'd1, 4'd1});
        chk("skip_serve", 32'(st[5]), 2);
        chk("skip_load_s2", {st[6], 1'b0, sl[6]}, {2'd1, 4'd2});

        // back-pressure
        do_reset();
        pesos = '0;
        set_slot(0, 2, 5);
        fill(0, 0, 10, 0);
        rst = 1'b0;
        enb = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.out_almost_full = (i >= 4 && i <= 6);
            tick();
        end
        bus.out_almost_full = 1'b0;
        chk("bp_pop_c2", 32'(pp[4]), 0);
        chk("bp_pop_c4", 32'(pp[6]), 0);
        chk("bp_pop_c1", 32'(pp[3]), 32'h4);
        chk("bp_credit_c1", 32'(cr[3]), 4);
        chk("bp_credit_hold", 32'(cr[6]), 4);
        chk("bp_slot_hold", {st[6], 1'b0, sl[6]}, {2'd2, 4'd0});
        chk("bp_pushes", 32'(pw.size()), 5);
        if (pw.size() == 5) begin
            chk("bp_first", 32'(pw[0]), 32'h80);
            chk("bp_last", 32'(pw[4]), 32'h84);
            chk("bp_last_tick", 32'(pt[4]), 10);
        end
        chk("bp_advance", {st[10], 1'b0, sl[10]}, {2'd1, 4'd1});

        // weight boundary
        do_reset();
        pesos = '0;
        set_slot(0, 0, 63);
        set_slot(1, 1, 1);
        fill(100, 100, 0, 0);
        rst = 1'b0;
        enb = 1'b1;
        for (int i = 0; i < 75; i++) tick();
        q0c   = 0;
        last0 = 0;
        for (int i = 0; i < pw.size(); i++)
            if (pw[i][7:6] == 2'd0 && pt[i] <= 70) begin
                q0c++;
                last0 = pt[i];
            end
        chk("wmax_q0_count", 32'(q0c), 63);
        chk("wmax_first_tick", 32'(pt[0]), 3);
        chk("wmax_last_tick", 32'(last0), 65);
        if (pw.size() > 63) begin
            chk("wmax_s1_word", 32'(pw[63]), 32'h40);
            chk("wmax_s1_tick", 32'(pt[63]), 67);
        end
        if (pw.size() > 64)
            chk("wmax_s1_once", 32'(pt[64]), 75);
        chk("wmax_slot7", 32'(sl[72]), 7);
        chk("wmax_wrap0", 32'(sl[73]), 0);

        // all-disabled
        do_reset();
        pesos = '0;
        fill(4, 4, 4, 4);
        rst = 1'b0;
        enb = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("dis_slot%0d", i), 32'(sl[i]), 32'((i - 1) % 8));
        end
        chk("dis_pop", 32'(pop_or), 0);
        chk("dis_push", 32'(pw.size()), 0);

        // reset mid-operation
        do_reset();
        pesos = '0;
        set_slot(0, 3, 4);
        fill(0, 0, 0, 20);
        rst = 1'b0;
        enb = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_pop2", 32'(pp[4]), 32'h8);
        rst = 1'b1;
        tick();
        chk("mid_rst_pop", 32'(pp[5]), 0);
        chk("mid_rst_push", 32'(bus.push), 0);
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_slot", 32'(slot), 0);

        // enable gap
        do_reset();
        rst = 1'b0;
        enb = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("gap_pre_credit", 32'(cr[3]), 3);
        chk("gap_pre_push", 32'(pw.size()), 1);
        enb = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("gap_pop", 32'(pp[4] | pp[5] | pp[6]), 0);
        chk("gap_push", 32'(pw.size()), 1);
        chk("gap_credit", 32'(cr[6]), 3);
        chk("gap_slot_state", {st[6], 1'b0, sl[6]}, {2'd2, 4'd0});
        enb = 1'b1;
        tick();
        chk("gap_resume_push", 32'(bus.push), 1);
        chk("gap_resume_credit", 32'(cr[7]), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
